// File: rtl/shift_ser_out_pkg.sv
// ============================================================================
// Module  : shift_ser_out_pkg
// Purpose : State encoding and sizing helpers shared by the 74LV595 serial
//           transmitter and the future LV165 serial-in controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_ser_out_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_SHIFT_LO = 2'd1;
  localparam state_t ST_SHIFT_HI = 2'd2;
  localparam state_t ST_LATCH    = 2'd3;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_ser_out_tick.sv
// ============================================================================
// Module  : shift_tick
// Purpose : CLK_DIV phase counter. Raises o_tick on the last cycle of each
//           phase; restarts from zero whenever the controller changes state.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_tick
  import shift_ser_out_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clear,
  output logic o_tick
);

  localparam int DIV_W = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] c_last = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = (r_cnt == c_last);

  // Phase counter: held at zero while disabled, restarts on state entry or phase end.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clear || !i_en || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_ser_out.sv
// ============================================================================
// Module  : shift_ser_out
// Purpose : Parallel-in, serial-out driver for a 74LV595-style register.
//           Shifts one word MSB first on SRCLK, then strobes RCLK. Every
//           pin-facing output comes straight from a flop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_ser_out
  import shift_ser_out_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_ser,
  output logic             o_srclk,
  output logic             o_rclk,
  output logic             o_done
);

  localparam int BIT_W = $clog2(WIDTH);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("shift_ser_out: WIDTH must be >= 2");
    end
    if (CLK_DIV < 1) begin : g_bad_div
      $error("shift_ser_out: CLK_DIV must be >= 1");
    end
  endgenerate

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_shift;
  logic [BIT_W-1:0]   r_bitcnt;
  logic               w_tick;
  logic               w_accept;
  logic               w_advance;
  logic               w_ser_nxt;
  logic               w_ready_nxt;
  logic               w_srclk_nxt;
  logic               w_rclk_nxt;
  logic               w_done_nxt;

  assign w_accept  = (r_state == ST_IDLE) && i_valid;
  // Leaving SHIFT_HI with more bits to send: move to the next bit.
  assign w_advance = (r_state == ST_SHIFT_HI) && w_tick && (r_bitcnt != '0);

  shift_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (r_state != ST_IDLE),
    .i_clear (w_next_state != r_state),
    .o_tick  (w_tick)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: each active phase lasts one full tick period.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (i_valid) w_next_state = ST_SHIFT_LO;
      ST_SHIFT_LO: if (w_tick)  w_next_state = ST_SHIFT_HI;
      ST_SHIFT_HI: if (w_tick)  w_next_state = (r_bitcnt == '0) ? ST_LATCH : ST_SHIFT_LO;
      ST_LATCH:    if (w_tick)  w_next_state = ST_IDLE;
      default:                  w_next_state = ST_IDLE;
    endcase
  end

  // Output decode: pin values for the upcoming cycle, registered below.
  // o_ser only moves when SRCLK is about to go low, giving full setup/hold.
  always_comb begin
    w_ser_nxt   = o_ser;
    if (w_accept) begin
      w_ser_nxt = i_data[WIDTH-1];
    end else if (w_advance) begin
      w_ser_nxt = r_shift[WIDTH-2];
    end
    w_ready_nxt = (w_next_state == ST_IDLE);
    w_srclk_nxt = (w_next_state == ST_SHIFT_HI);
    w_rclk_nxt  = (w_next_state == ST_LATCH);
    w_done_nxt  = (r_state == ST_LATCH) && (w_next_state == ST_IDLE);
  end

  // Pin registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_ready <= 1'b1;
      o_ser   <= 1'b0;
      o_srclk <= 1'b0;
      o_rclk  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_ready <= w_ready_nxt;
      o_ser   <= w_ser_nxt;
      o_srclk <= w_srclk_nxt;
      o_rclk  <= w_rclk_nxt;
      o_done  <= w_done_nxt;
    end
  end

  // Word register and bit counter; rotate keeps the next bit at the MSB.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else if (w_accept) begin
      r_shift  <= i_data;
      r_bitcnt <= BIT_W'(WIDTH - 1);
    end else if (w_advance) begin
      r_shift  <= {r_shift[WIDTH-2:0], r_shift[WIDTH-1]};
      r_bitcnt <= r_bitcnt - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_ser_out.sv
// ============================================================================
// Module  : tb_shift_ser_out
// Purpose : Self-checking bench. Two instances (8-bit/div 2 and 16-bit/div 1)
//           drive behavioural 74LV595 models; latched words, edge counts and
//           accept-to-done latency are compared with bench expectations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_ser_out;

  localparam int WA = 8;
  localparam int DA = 2;
  localparam int WB = 16;
  localparam int DB = 1;
  localparam int LAT_A = 2 * DA * WA + DA;
  localparam int LAT_B = 2 * DB * WB + DB;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic [WA-1:0] a_data = '0;
  logic          a_valid = 1'b0;
  logic          a_ready, a_ser, a_srclk, a_rclk, a_done;
  logic [WB-1:0] b_data = '0;
  logic          b_valid = 1'b0;
  logic          b_ready, b_ser, b_srclk, b_rclk, b_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_ser_out #(.WIDTH(WA), .CLK_DIV(DA)) dut_a (
    .i_clk(clk), .i_reset(rst_a), .i_data(a_data), .i_valid(a_valid),
    .o_ready(a_ready), .o_ser(a_ser), .o_srclk(a_srclk), .o_rclk(a_rclk),
    .o_done(a_done)
  );

  shift_ser_out #(.WIDTH(WB), .CLK_DIV(DB)) dut_b (
    .i_clk(clk), .i_reset(rst_b), .i_data(b_data), .i_valid(b_valid),
    .o_ready(b_ready), .o_ser(b_ser), .o_srclk(b_srclk), .o_rclk(b_rclk),
    .o_done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural 595 models: shift stage clocked by SRCLK, storage by RCLK.
  logic [WA-1:0] sr_a = '0, latch_a = '0;
  logic [WB-1:0] sr_b = '0, latch_b = '0;
  logic a_srclk_q = 1'b0, a_rclk_q = 1'b0, a_ser_q = 1'b0;
  logic b_srclk_q = 1'b0, b_rclk_q = 1'b0, b_ser_q = 1'b0;
  int edges_a = 0, rclks_a = 0, edges_b = 0, rclks_b = 0;

  always @(negedge clk) begin
    if (a_srclk && !a_srclk_q) begin
      chk("a_ser_setup", {31'd0, a_ser}, {31'd0, a_ser_q});
      sr_a = {sr_a[WA-2:0], a_ser};
      edges_a++;
    end
    if (a_rclk && !a_rclk_q) begin
      latch_a = sr_a;
      rclks_a++;
    end
    if (b_srclk && !b_srclk_q) begin
      chk("b_ser_setup", {31'd0, b_ser}, {31'd0, b_ser_q});
      sr_b = {sr_b[WB-2:0], b_ser};
      edges_b++;
    end
    if (b_rclk && !b_rclk_q) begin
      latch_b = sr_b;
      rclks_b++;
    end
    a_srclk_q = a_srclk; a_rclk_q = a_rclk; a_ser_q = a_ser;
    b_srclk_q = b_srclk; b_rclk_q = b_rclk; b_ser_q = b_ser;
  end

  // Count edges after the accept edge until o_done; optional ignored i_valid pulse on A.
  task automatic wait_done(input bit sel_b, input int noise_cyc, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == noise_cyc) begin
        a_valid = 1'b1;
        a_data  = 8'hFF;
      end else if (cyc == noise_cyc + 1) begin
        a_valid = 1'b0;
      end
      if (sel_b ? b_done : a_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk(sel_b ? "b_done_timeout" : "a_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_a(input logic [WA-1:0] w, input int noise_cyc);
    int cyc;
    @(negedge clk);
    chk("a_ready_pre", {31'd0, a_ready}, 32'd1);
    a_data  = w;
    a_valid = 1'b1;
    @(posedge clk);
    edges_a = 0;
    rclks_a = 0;
    #1;
    a_valid = 1'b0;
    a_data  = WA'($urandom);
    wait_done(1'b0, noise_cyc, cyc);
    chk("a_latency", cyc, LAT_A);
    chk("a_ready_done", {31'd0, a_ready}, 32'd1);
    chk("a_srclk_edges", edges_a, WA);
    chk("a_rclk_pulses", rclks_a, 32'd1);
    chk("a_latched", {24'd0, latch_a}, {24'd0, w});
    @(posedge clk);
    #1;
    chk("a_done_pulse", {31'd0, a_done}, 32'd0);
  endtask

  task automatic send_b(input logic [WB-1:0] w);
    int cyc;
    @(negedge clk);
    b_data  = w;
    b_valid = 1'b1;
    @(posedge clk);
    edges_b = 0;
    rclks_b = 0;
    #1;
    b_valid = 1'b0;
    b_data  = WB'($urandom);
    wait_done(1'b1, -5, cyc);
    chk("b_latency", cyc, LAT_B);
    chk("b_srclk_edges", edges_b, WB);
    chk("b_rclk_pulses", rclks_b, 32'd1);
    chk("b_latched", {16'd0, latch_b}, {16'd0, w});
  endtask

  initial begin
    int cyc;
    bit quiet;
    logic [WA-1:0] wr;

    // Reset state and idle quiet period.
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, a_ready}, 32'd1);
    chk("rst_outs", {28'd0, a_ser, a_srclk, a_rclk, a_done}, 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!a_ready || a_ser || a_srclk || a_rclk || a_done) quiet = 1'b0;
      if (!b_ready || b_ser || b_srclk || b_rclk || b_done) quiet = 1'b0;
    end
    chk("idle_quiet", {31'd0, quiet}, 32'd1);

    // Single word.
    send_a(8'hA5, -5);

    // Reset in the middle of 8'h3C: no RCLK, storage keeps 8'hA5.
    @(negedge clk);
    a_data  = 8'h3C;
    a_valid = 1'b1;
    @(posedge clk);
    edges_a = 0;
    rclks_a = 0;
    #1 a_valid = 1'b0;
    for (int k = 0; k < 100 && edges_a < 4; k++) @(negedge clk);
    chk("rst_mid_reached", {31'd0, edges_a >= 4}, 32'd1);
    rst_a = 1'b1;
    #1;
    chk("rst_mid_ready", {31'd0, a_ready}, 32'd1);
    chk("rst_mid_outs", {28'd0, a_ser, a_srclk, a_rclk, a_done}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_rclk", rclks_a, 32'd0);
    chk("rst_mid_latch", {24'd0, latch_a}, 32'h0000_00A5);
    rst_a = 1'b0;
    send_a(8'h5A, -5);

    // Back-to-back with i_valid held; data change during word 1 has no effect.
    @(negedge clk);
    a_data  = 8'h01;
    a_valid = 1'b1;
    @(posedge clk);
    edges_a = 0;
    rclks_a = 0;
    #1 a_data = 8'h80;
    wait_done(1'b0, -5, cyc);
    chk("b2b_lat1", cyc, LAT_A);
    chk("b2b_word1", {24'd0, latch_a}, 32'h0000_0001);
    edges_a = 0;
    rclks_a = 0;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    chk("b2b_one_idle", {31'd0, a_ready}, 32'd0);
    wait_done(1'b0, -5, cyc);
    chk("b2b_lat2", cyc, LAT_A);
    chk("b2b_edges2", edges_a, WA);
    chk("b2b_word2", {24'd0, latch_a}, 32'h0000_0080);

    // i_valid pulsed with 8'hFF while busy is ignored.
    send_a(8'h42, 10);

    // Randomized words with random gaps and random busy-time pulses.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      wr = WA'($urandom);
      send_a(wr, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 25)) : -5);
    end

    // Wide, fastest divider instance.
    send_b(16'hBEEF);
    for (int i = 0; i < 4; i++) send_b(WB'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
